// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: one shared edge/center-aligned counter, per-channel duty,
// configuration double-buffered to period boundaries. Optional: PWM_DAC_MULTI_INVERT_EN.
module pwm_dac_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 9,
    parameter int COUNT_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] duty_cycle,
    input  logic [COUNT_WIDTH-1:0]    count_value,
    input  logic                      center_mode,
`ifdef PWM_DAC_MULTI_INVERT_EN
    input  logic [CHANNELS-1:0]       invert,
`endif
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      zero,
    output logic                      update_pending,
    output logic                      update_ack
);

    localparam int CMP_W = (WIDTH > COUNT_WIDTH) ? WIDTH : COUNT_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0]    counter;
    logic                      dir;
    logic [CHANNELS*WIDTH-1:0] active_duty, pending_duty;
    logic [COUNT_WIDTH-1:0]    active_period, pending_period;
    logic                      active_mode, pending_mode;
`ifdef PWM_DAC_MULTI_INVERT_EN
    logic [CHANNELS-1:0]       active_invert, pending_invert;
`endif

    logic period_end;
    logic apply;

    // Center mode ends its period on the way down at 1; P=0 makes every cycle an end.
    always_comb begin
        period_end = 1'b0;
        if (enable) begin
            if (active_period == '0)
                period_end = 1'b1;
            else if (active_mode)
                period_end = dir && (counter <= ONE);
            else
                period_end = (counter >= active_period);
        end
    end

    assign apply = period_end && (update_pending || load);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            counter        <= '0;
            dir            <= 1'b0;
            active_duty    <= '0;
            pending_duty   <= '0;
            active_period  <= '0;
            pending_period <= '0;
            active_mode    <= 1'b0;
            pending_mode   <= 1'b0;
`ifdef PWM_DAC_MULTI_INVERT_EN
            active_invert  <= '0;
            pending_invert <= '0;
`endif
            update_pending <= 1'b0;
            update_ack     <= 1'b0;
        end else begin
            update_ack <= 1'b0;
            if (load) begin
                pending_duty   <= duty_cycle;
                pending_period <= count_value;
                pending_mode   <= center_mode;
`ifdef PWM_DAC_MULTI_INVERT_EN
                pending_invert <= invert;
`endif
            end
            if (apply) begin
                // A load coinciding with the boundary bypasses the pending stage.
                active_duty    <= load ? duty_cycle  : pending_duty;
                active_period  <= load ? count_value : pending_period;
                active_mode    <= load ? center_mode : pending_mode;
`ifdef PWM_DAC_MULTI_INVERT_EN
                active_invert  <= load ? invert      : pending_invert;
`endif
                counter        <= '0;
                dir            <= 1'b0;
                update_pending <= 1'b0;
                update_ack     <= 1'b1;
            end else begin
                if (load)
                    update_pending <= 1'b1;
                if (enable) begin
                    if (period_end) begin
                        counter <= '0;
                        dir     <= 1'b0;
                    end else if (!active_mode) begin
                        counter <= counter + ONE;
                    end else if (!dir) begin
                        counter <= counter + ONE;
                        if (counter + ONE >= active_period)
                            dir <= 1'b1;
                    end else begin
                        counter <= counter - ONE;
                    end
                end
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_out[i] = CMP_W'(counter) < CMP_W'(active_duty[i*WIDTH +: WIDTH]);
`ifdef PWM_DAC_MULTI_INVERT_EN
            pwm_out[i] = pwm_out[i] ^ active_invert[i];
`endif
        end
    end

    assign zero = (counter == '0);

endmodule
